// File: rtl/registro_estado.sv
// State register for the elevator controller. It tracks the current and previous
// state, pulses on change, counts dwell edges and flags illegal next-state codes.
module registro_estado #(
  parameter int WIDTH       = 4,
  parameter int NUM_STATES  = 10,
  parameter int RESET_STATE = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     D,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     Q_prev,
  output logic                 changed,
  output logic [CNT_WIDTH-1:0] dwell,
  output logic                 illegal,
  output logic                 illegal_sticky
);

  localparam logic [WIDTH-1:0]     RESET_CODE = WIDTH'(RESET_STATE);
  localparam logic [CNT_WIDTH-1:0] DWELL_MAX  = '1;

  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_q_prev;
  logic                 r_changed;
  logic [CNT_WIDTH-1:0] r_dwell;
  logic                 r_illegal;
  logic                 r_illegal_sticky;

  logic                 w_illegal;
  logic                 w_differs;
  logic [CNT_WIDTH-1:0] w_dwell_inc;

  // With a full code space every sample is legal, so the detector is a constant.
  generate
    if (NUM_STATES >= (2 ** WIDTH)) begin : g_full_code_space
      assign w_illegal = 1'b0;
    end else begin : g_partial_code_space
      localparam logic [WIDTH-1:0] LAST_LEGAL = WIDTH'(NUM_STATES - 1);
      assign w_illegal = (D > LAST_LEGAL);
    end
  endgenerate

  assign w_differs   = (D != r_q);
  assign w_dwell_inc = (r_dwell == DWELL_MAX) ? r_dwell : r_dwell + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q              <= RESET_CODE;
      r_q_prev         <= RESET_CODE;
      r_changed        <= 1'b0;
      r_dwell          <= '0;
      r_illegal        <= 1'b0;
      r_illegal_sticky <= 1'b0;
    end else if (w_illegal) begin
      // An illegal code is rejected: Q holds, so the dwell count keeps running.
      r_q_prev         <= r_q;
      r_changed        <= 1'b0;
      r_dwell          <= w_dwell_inc;
      r_illegal        <= 1'b1;
      r_illegal_sticky <= 1'b1;
    end else begin
      r_q       <= D;
      r_q_prev  <= r_q;
      r_changed <= w_differs;
      r_dwell   <= w_differs ? '0 : w_dwell_inc;
      r_illegal <= 1'b0;
    end
  end

  assign Q              = r_q;
  assign Q_prev         = r_q_prev;
  assign changed        = r_changed;
  assign dwell          = r_dwell;
  assign illegal        = r_illegal;
  assign illegal_sticky = r_illegal_sticky;

endmodule

// File: tb/tb_registro_estado.sv
// Directed bench for registro_estado: default build plus a CNT_WIDTH=3 build
// used to reach dwell saturation quickly.
module tb_registro_estado;

  logic        clk;
  logic        reset;
  logic [3:0]  D;
  logic [3:0]  Q;
  logic [3:0]  Q_prev;
  logic        changed;
  logic [15:0] dwell;
  logic        illegal;
  logic        illegal_sticky;

  logic [3:0]  d_s;
  logic [3:0]  q_s;
  logic [3:0]  q_prev_s;
  logic        changed_s;
  logic [2:0]  dwell_s;
  logic        illegal_s;
  logic        illegal_sticky_s;

  int n_cmp;
  int n_fail;

  registro_estado dut (
    .clk            (clk),
    .reset          (reset),
    .D              (D),
    .Q              (Q),
    .Q_prev         (Q_prev),
    .changed        (changed),
    .dwell          (dwell),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky)
  );

  registro_estado #(.CNT_WIDTH(3)) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .D              (d_s),
    .Q              (q_s),
    .Q_prev         (q_prev_s),
    .changed        (changed_s),
    .dwell          (dwell_s),
    .illegal        (illegal_s),
    .illegal_sticky (illegal_sticky_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed bundle order: Q, Q_prev, changed, illegal, illegal_sticky, dwell.
  task automatic test_reset();
    reset = 1'b1;
    D     = 4'd7;
    d_s   = 4'd7;
    step();
    step();
    n_cmp++;
    if ({Q, Q_prev, changed, illegal, illegal_sticky, dwell} !==
        {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset: got Q=%0d Qp=%0d chg=%b ill=%b stk=%b dwell=%0d, need 0 0 0 0 0 0",
               Q, Q_prev, changed, illegal, illegal_sticky, dwell);
    end
  endtask

  task automatic test_load();
    logic [3:0]  d_v   [4] = '{4'd3, 4'd5, 4'd5, 4'd9};
    logic [3:0]  q_v   [4] = '{4'd3, 4'd5, 4'd5, 4'd9};
    logic [3:0]  qp_v  [4] = '{4'd0, 4'd3, 4'd5, 4'd5};
    logic        chg_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] dw_v  [4] = '{16'd0, 16'd0, 16'd1, 16'd0};
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      D = d_v[i];
      step();
      n_cmp++;
      if ({Q, Q_prev, changed, illegal, illegal_sticky, dwell} !==
          {q_v[i], qp_v[i], chg_v[i], 1'b0, 1'b0, dw_v[i]}) begin
        n_fail++;
        $display("FAIL load[%0d]: got Q=%0d Qp=%0d chg=%b ill=%b stk=%b dwell=%0d, need %0d %0d %b 0 0 %0d",
                 i, Q, Q_prev, changed, illegal, illegal_sticky, dwell,
                 q_v[i], qp_v[i], chg_v[i], dw_v[i]);
      end
    end
  endtask

  task automatic test_illegal();
    D = 4'd4;
    step();
    n_cmp++;
    if ({Q, Q_prev, changed, dwell} !== {4'd4, 4'd9, 1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL illegal_setup: got Q=%0d Qp=%0d chg=%b dwell=%0d, need 4 9 1 0",
               Q, Q_prev, changed, dwell);
    end
    D = 4'd12;
    step();
    n_cmp++;
    if ({Q, Q_prev, changed, illegal, illegal_sticky, dwell} !==
        {4'd4, 4'd4, 1'b0, 1'b1, 1'b1, 16'd1}) begin
      n_fail++;
      $display("FAIL illegal_hit: got Q=%0d Qp=%0d chg=%b ill=%b stk=%b dwell=%0d, need 4 4 0 1 1 1",
               Q, Q_prev, changed, illegal, illegal_sticky, dwell);
    end
    D = 4'd4;
    step();
    n_cmp++;
    if ({Q, Q_prev, changed, illegal, illegal_sticky, dwell} !==
        {4'd4, 4'd4, 1'b0, 1'b0, 1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL illegal_after: got Q=%0d Qp=%0d chg=%b ill=%b stk=%b dwell=%0d, need 4 4 0 0 1 2",
               Q, Q_prev, changed, illegal, illegal_sticky, dwell);
    end
    // Boundary: 10 is the first illegal code, 9 the last legal one.
    D = 4'd10;
    step();
    n_cmp++;
    if ({Q, illegal, illegal_sticky} !== {4'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_10: got Q=%0d ill=%b stk=%b, need 4 1 1", Q, illegal, illegal_sticky);
    end
    D = 4'd9;
    step();
    n_cmp++;
    if ({Q, changed, illegal} !== {4'd9, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL legal_9: got Q=%0d chg=%b ill=%b, need 9 1 0", Q, changed, illegal);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      D = 4'(3 + i);
      step();
      n_cmp++;
      if ({Q, changed, dwell} !== {4'(3 + i), 1'b1, 16'd0}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got Q=%0d chg=%b dwell=%0d, need %0d 1 0",
                 i, Q, changed, dwell, 3 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Q=6 is already held; raise the sticky flag first.
    D = 4'd15;
    step();
    n_cmp++;
    if ({Q, illegal_sticky} !== {4'd6, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_setup: got Q=%0d stk=%b, need 6 1", Q, illegal_sticky);
    end
    reset = 1'b1;
    D     = 4'd8;
    step();
    n_cmp++;
    if ({Q, Q_prev, changed, illegal, illegal_sticky, dwell} !==
        {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got Q=%0d Qp=%0d chg=%b ill=%b stk=%b dwell=%0d, need 0 0 0 0 0 0",
               Q, Q_prev, changed, illegal, illegal_sticky, dwell);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({Q, Q_prev, changed, illegal, dwell} !== {4'd8, 4'd0, 1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL mid_release: got Q=%0d Qp=%0d chg=%b ill=%b dwell=%0d, need 8 0 1 0 0",
               Q, Q_prev, changed, illegal, dwell);
    end
  endtask

  task automatic test_edge_sampling();
    D = 4'd1;
    step();
    D = 4'd2;
    #30;
    n_cmp++;
    if (Q !== 4'd1) begin
      n_fail++;
      $display("FAIL between_edges_a: got Q=%0d, need 1", Q);
    end
    D = 4'd1;
    #30;
    n_cmp++;
    if (Q !== 4'd1) begin
      n_fail++;
      $display("FAIL between_edges_b: got Q=%0d, need 1", Q);
    end
    step();
    n_cmp++;
    if ({Q, changed, dwell} !== {4'd1, 1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL sampled_1: got Q=%0d chg=%b dwell=%0d, need 1 0 1", Q, changed, dwell);
    end
    D = 4'd2;
    step();
    n_cmp++;
    if ({Q, Q_prev, changed} !== {4'd2, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL sampled_2: got Q=%0d Qp=%0d chg=%b, need 2 1 1", Q, Q_prev, changed);
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_s   = 4'd2;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({q_s, changed_s, dwell_s} !== {4'd2, (i == 0), 3'((i > 7) ? 7 : i)}) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got Q=%0d chg=%b dwell=%0d, need 2 %b %0d",
                 i, q_s, changed_s, dwell_s, (i == 0), (i > 7) ? 7 : i);
      end
    end
    d_s = 4'd3;
    step();
    n_cmp++;
    if ({q_s, changed_s, dwell_s} !== {4'd3, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL saturation_exit: got Q=%0d chg=%b dwell=%0d, need 3 1 0", q_s, changed_s, dwell_s);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    D      = '0;
    d_s    = '0;
    test_reset();
    test_load();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_edge_sampling();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/registro_estado.md
# registro_estado

Clocked state register for the elevator controller. Every rising edge of `clk` it captures the next-state code `D` from the controller's next-state logic and presents it as the current state `Q`. It also provides the bookkeeping the rest of the controller needs:
- the previous state;
- a state-change pulse;
- a dwell-time counter;
- illegal-code detection.

All outputs are registered.

## Interface
Parameters:
- `WIDTH`, 4: width of the state code on `D`, `Q` and `Q_prev`.
- `NUM_STATES`, 10: legal codes are 0 .. `NUM_STATES`-1. Must satisfy 1 ≤ `NUM_STATES` ≤ 2^`WIDTH`.
- `RESET_STATE`, 0: value loaded into `Q` and `Q_prev` on reset. Must be a legal code.
- `CNT_WIDTH`, 16: width of the `dwell` counter.

Ports:
- `clk`  in  1  rising-edge clock; the only clock of the block.
- `reset`  in  1  synchronous, active-high reset; sampled on the `clk` rising edge.
- `D`  in  `WIDTH`  next-state code, sampled every rising edge.
- `Q`  out  `WIDTH`  current state.
- `Q_prev`  out  `WIDTH`  state held in `Q` before its most recent update.
- `changed`  out  1  one-cycle pulse: the last edge loaded a value different from the old `Q`.
- `dwell`  out  `CNT_WIDTH`  number of edges since `Q` last changed; saturating.
- `illegal`  out  1  the last sampled `D` was ≥ `NUM_STATES`.
- `illegal_sticky`  out  1  set by any illegal sample; cleared only by reset.

## Operation
Reset has priority over everything. On a rising edge with `reset`=1:
- `Q` = `Q_prev` = `RESET_STATE`;
- `changed` = 0, `illegal` = 0, `illegal_sticky` = 0, `dwell` = 0.

Legal sample (`reset`=0, `D` < `NUM_STATES`), on the rising edge:
- `Q` ← `D`; `Q_prev` ← old `Q`.
- `changed` ← (`D` ≠ old `Q`).
- `dwell` ← 0 if `D` ≠ old `Q`; otherwise `dwell`+1, saturating at 2^`CNT_WIDTH`−1.
- `illegal` ← 0; `illegal_sticky` unchanged.

Illegal sample (`reset`=0, `D` ≥ `NUM_STATES`), on the rising edge:
- `Q` holds its value; `Q_prev` ← old `Q`.
- `changed` ← 0; `dwell` increments with saturation.
- `illegal` ← 1; `illegal_sticky` ← 1.

General rules:
- Compare as unsigned values.
- No load enable: `D` is sampled on every edge.
- When `NUM_STATES` = 2^`WIDTH`, the illegal logic must reduce to constant 0.
- `D` must be a known value (no X/Z) whenever `reset`=0.

## Timing
- Latency is exactly one cycle: `D` sampled at edge n appears on `Q` right after edge n and is held until edge n+1.
- Every output is driven directly by a flop. There are no combinational paths from input to output.
- `changed` and `illegal` are high for exactly one cycle per qualifying edge.
- Back-to-back changes give consecutive `changed` pulses with `dwell` held at 0.
- Reset asserted mid-operation takes effect at the next edge, regardless of `D`.
- On the first edge after reset deasserts, `D` is compared against `RESET_STATE`.
- Outputs change only on rising edges of `clk`. Between edges, a change on `D` has no effect.
- Reference clock period is 100 ns. The design must close timing well below this.

## Test plan
Defaults apply (`WIDTH` 4, `NUM_STATES` 10, `RESET_STATE` 0, `CNT_WIDTH` 16); one edge every 100 ns.
- Reset: hold `reset`=1 with `D`=7 for 2 edges → `Q`=0, `Q_prev`=0, `dwell`=0, `changed`=0, `illegal_sticky`=0.
- Load sequence: `D`=3, 5, 5, 9 on consecutive edges after reset → sequences below, one value per edge:
  - `Q`: 3, 5, 5, 9
  - `Q_prev`: 0, 3, 5, 5
  - `changed`: 1, 1, 0, 1
  - `dwell`: 0, 0, 1, 0
- Illegal code: with `Q`=4, apply `D`=12 for one edge, then `D`=4 →
  - after the first edge: `Q`=4, `illegal`=1, `illegal_sticky`=1, `changed`=0;
  - after the next edge: `illegal`=0, `illegal_sticky`=1.
- Dwell saturation: build with `CNT_WIDTH`=3 and hold `D`=2 for 10 edges → `dwell` goes 0, 1, …, 7 and stays at 7.
- Reset mid-run: with `Q`=6 and `illegal_sticky`=1, pulse `reset` for one edge while `D`=8 → `Q`=0, `illegal_sticky`=0. The next edge with `D`=8 gives `Q`=8, `changed`=1.
- Edge-only sampling: toggle `D` 1→2→1 between edges → `Q` updates only at edges and reflects `D` as sampled at each edge.
